// File: rtl/pe_row_conv.sv
// Row-stationary PE: stores one filter row and one activation row and streams 1-D convolution partial sums.
// Optional PE_PSUM_SAT_EN: saturating accumulation instead of two's-complement wrap.
module pe_row_conv #(
    parameter int DATA_BITWIDTH = 16,
    parameter int PSUM_BITWIDTH = 32,
    parameter int KERNEL_MAX    = 8,
    parameter int ACT_MAX       = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(KERNEL_MAX+1)-1:0]      cfg_kernel_size,
    input  logic [$clog2(ACT_MAX+1)-1:0]         cfg_act_len,
    input  logic [3:0]                           cfg_stride,
    input  logic                                 cfg_use_psum_in,
    input  logic                                 start,
    input  logic signed [DATA_BITWIDTH-1:0]      wght_in,
    input  logic                                 wght_valid,
    output logic                                 wght_ready,
    input  logic signed [DATA_BITWIDTH-1:0]      act_in,
    input  logic                                 act_valid,
    output logic                                 act_ready,
    input  logic signed [PSUM_BITWIDTH-1:0]      psum_in,
    input  logic                                 psum_in_valid,
    output logic                                 psum_in_ready,
    output logic signed [PSUM_BITWIDTH-1:0]      psum_out,
    output logic                                 psum_out_valid,
    input  logic                                 psum_out_ready,
    output logic                                 busy,
    output logic                                 load_done,
    output logic                                 compute_done,
    output logic                                 cfg_err
);

    localparam int DW  = DATA_BITWIDTH;
    localparam int PW  = PSUM_BITWIDTH;
    localparam int KW  = $clog2(KERNEL_MAX+1);
    localparam int LW  = $clog2(ACT_MAX+1);
    localparam int KIW = (KERNEL_MAX > 1) ? $clog2(KERNEL_MAX) : 1;
    localparam int AIW = (ACT_MAX > 1) ? $clog2(ACT_MAX) : 1;
    localparam int EW  = ((KW > LW) ? KW : LW) + 5;

    localparam logic signed [PW-1:0] PSUM_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] PSUM_MIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, MAC, ACC, OUT} state_t;

    state_t                state;
    logic [KW-1:0]         k_len;
    logic [LW-1:0]         l_len;
    logic [3:0]            stride;
    logic                  use_psum;
    logic [KW-1:0]         w_idx;
    logic [KW-1:0]         w_len;
    logic [LW-1:0]         a_idx;
    logic [LW-1:0]         a_len;
    logic [KW-1:0]         k_idx;
    logic [LW-1:0]         a_base;
    logic signed [PW-1:0]  acc;

    logic signed [DW-1:0]  wght_mem [2**KIW];
    logic signed [DW-1:0]  act_mem  [2**AIW];

    logic [EW-1:0]         cfg_k_e;
    logic [EW-1:0]         cfg_l_e;
    logic                  start_bad;
    logic                  more_out;
    logic [AIW-1:0]        a_addr;
    logic signed [2*DW-1:0] product;
    logic signed [PW-1:0]  product_ext;
    logic [KW-1:0]         w_wr_idx;
    logic [LW-1:0]         a_wr_idx;
    logic                  w_wr_en;
    logic                  a_wr_en;

    function automatic logic signed [PW-1:0] psum_add(input logic signed [PW-1:0] x,
                                                      input logic signed [PW-1:0] y);
`ifdef PE_PSUM_SAT_EN
        logic [PW:0] sum;
        sum = {x[PW-1], x} + {y[PW-1], y};
        if (sum[PW] != sum[PW-1])
            psum_add = sum[PW] ? PSUM_MIN : PSUM_MAX;
        else
            psum_add = sum[PW-1:0];
`else
        psum_add = x + y;
`endif
    endfunction

    assign cfg_k_e   = EW'(cfg_kernel_size);
    assign cfg_l_e   = EW'(cfg_act_len);
    assign start_bad = (cfg_k_e == '0) || (cfg_k_e > EW'(KERNEL_MAX)) ||
                       (cfg_l_e < cfg_k_e) || (cfg_l_e > EW'(ACT_MAX)) ||
                       (cfg_stride == 4'd0);

    // Another output exists if the next window still fits inside the activation row.
    assign more_out = (EW'(a_base) + EW'(stride) + EW'(k_len)) <= EW'(l_len);

    assign a_addr      = a_base[AIW-1:0] + AIW'(k_idx);
    assign product     = wght_mem[k_idx[KIW-1:0]] * act_mem[a_addr];
    assign product_ext = PW'(product);

    // IDLE arbitration order is start, then weights, then activations.
    assign wght_ready     = (state == IDLE && !start) || (state == LOAD_W);
    assign act_ready      = (state == IDLE && !start && !wght_valid) || (state == LOAD_A);
    assign psum_in_ready  = (state == ACC) && use_psum;
    assign psum_out_valid = (state == OUT);
    assign busy           = (state != IDLE);

    assign w_wr_idx = (state == LOAD_W) ? w_idx : '0;
    assign a_wr_idx = (state == LOAD_A) ? a_idx : '0;
    assign w_wr_en  = !reset && wght_valid && wght_ready && (EW'(w_wr_idx) < EW'(KERNEL_MAX));
    assign a_wr_en  = !reset && act_valid && act_ready && (EW'(a_wr_idx) < EW'(ACT_MAX));

    always_ff @(posedge clk) begin
        if (w_wr_en)
            wght_mem[w_wr_idx[KIW-1:0]] <= wght_in;
        if (a_wr_en)
            act_mem[a_wr_idx[AIW-1:0]] <= act_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            k_len        <= '0;
            l_len        <= '0;
            stride       <= '0;
            use_psum     <= 1'b0;
            w_idx        <= '0;
            w_len        <= '0;
            a_idx        <= '0;
            a_len        <= '0;
            k_idx        <= '0;
            a_base       <= '0;
            acc          <= '0;
            psum_out     <= '0;
            load_done    <= 1'b0;
            compute_done <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            load_done    <= 1'b0;
            compute_done <= 1'b0;
            cfg_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            k_len    <= cfg_kernel_size;
                            l_len    <= cfg_act_len;
                            stride   <= cfg_stride;
                            use_psum <= cfg_use_psum_in;
                            a_base   <= '0;
                            k_idx    <= '0;
                            acc      <= '0;
                            state    <= MAC;
                        end
                    end else if (wght_valid) begin
                        w_len <= cfg_kernel_size;
                        w_idx <= KW'(1);
                        if (cfg_kernel_size <= KW'(1))
                            load_done <= 1'b1;
                        else
                            state <= LOAD_W;
                    end else if (act_valid) begin
                        a_len <= cfg_act_len;
                        a_idx <= LW'(1);
                        if (cfg_act_len <= LW'(1))
                            load_done <= 1'b1;
                        else
                            state <= LOAD_A;
                    end
                end
                LOAD_W: begin
                    if (wght_valid) begin
                        if (w_idx == w_len - KW'(1)) begin
                            load_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            w_idx <= w_idx + KW'(1);
                        end
                    end
                end
                LOAD_A: begin
                    if (act_valid) begin
                        if (a_idx == a_len - LW'(1)) begin
                            load_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            a_idx <= a_idx + LW'(1);
                        end
                    end
                end
                MAC: begin
                    acc <= psum_add(acc, product_ext);
                    if (k_idx == k_len - KW'(1))
                        state <= ACC;
                    else
                        k_idx <= k_idx + KW'(1);
                end
                ACC: begin
                    if (!use_psum || psum_in_valid) begin
                        psum_out <= psum_add(acc, use_psum ? psum_in : '0);
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (psum_out_ready) begin
                        if (more_out) begin
                            a_base <= a_base + LW'(stride);
                            k_idx  <= '0;
                            acc    <= '0;
                            state  <= MAC;
                        end else begin
                            compute_done <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pe_row_conv.md
# pe_row_conv

Parametrised row-stationary processing element for the Eyeriss-style array: holds one filter row and one activation row in internal scratchpads and produces a stream of 1-D convolution partial sums. It adds runtime-configurable kernel length, activation length and stride. It also accumulates an incoming partial sum from the PE below and drives results upward through valid/ready handshakes.

## Interface
- DATA_BITWIDTH, 16, signed weight/activation width
- PSUM_BITWIDTH, 32, signed partial-sum width (>= 2*DATA_BITWIDTH)
- KERNEL_MAX, 8, weight scratchpad depth
- ACT_MAX, 32, activation scratchpad depth
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_kernel_size  in  $clog2(KERNEL_MAX+1)  filter row length K
- cfg_act_len  in  $clog2(ACT_MAX+1)  activation row length L
- cfg_stride  in  4  stride S
- cfg_use_psum_in  in  1  1 = add psum_in to each output, 0 = add zero
- start  in  1  begin a compute pass (level, sampled in IDLE)
- wght_in / wght_valid / wght_ready  in/in/out  DATA_BITWIDTH/1/1  weight load stream
- act_in / act_valid / act_ready  in/in/out  DATA_BITWIDTH/1/1  activation load stream
- psum_in / psum_in_valid / psum_in_ready  in/in/out  PSUM_BITWIDTH/1/1  partial sum from neighbour
- psum_out / psum_out_valid / psum_out_ready  out/out/in  PSUM_BITWIDTH/1/1  result stream
- busy  out  1  high in any state except IDLE
- load_done  out  1  one-cycle pulse after the last load beat
- compute_done  out  1  one-cycle pulse after the last output handshake
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, LOAD_W, LOAD_A, MAC, ACC, OUT.
- IDLE priority: start > wght_valid > act_valid.
- Load, weights:
  - wght_ready is high in IDLE (when start is low) and in LOAD_W.
  - The first beat writes index 0, the state becomes LOAD_W and K is sampled on that beat.
  - After beat K-1 the state returns to IDLE and load_done pulses.
- Load, activations: same scheme using L and act_ready.
- Scratchpad contents persist across passes, so a second start reuses the loaded data without reloading.
- Start checks: start is rejected with a cfg_err pulse, staying in IDLE, if any of these hold:
  - K == 0 or K > KERNEL_MAX
  - L < K or L > ACT_MAX
  - S == 0
- Accepted start:
  - Latches K, L, S and use_psum_in.
  - Output count N = floor((L-K)/S)+1.
  - Output index o = 0.
  - Next state is MAC.
- MAC: one product per cycle over k = 0..K-1, acc += w[k]*a[o*S+k]. Each product is a full 2*DATA_BITWIDTH signed value, sign-extended to PSUM_BITWIDTH. acc clears at entry to each output.
- ACC:
  - psum_in_ready = 1 when use_psum_in.
  - Waits for psum_in_valid, then adds psum_in.
  - When use_psum_in = 0, adds zero and leaves in one cycle.
- OUT:
  - psum_out_valid = 1 while psum_out holds the result.
  - On handshake, o increments. If o < N the next state is MAC; otherwise compute_done pulses and the state is IDLE.
- During a pass, wght_ready = act_ready = 0. Load beats are not consumed and start is ignored.
- Additions wrap modulo 2^PSUM_BITWIDTH unless PE_PSUM_SAT_EN is defined.

## Timing
- Reset values:
  - All outputs 0, psum_out = 0, state IDLE, counters 0.
  - Scratchpad contents are unchanged and undefined after power-up.
- Reset mid-load or mid-pass aborts to IDLE next cycle with no done pulse. The loaded row must then be considered invalid.
- Loads take one beat per cycle when valid is held. load_done pulses the cycle after the last beat.
- Pass latency, with no stalls:
  - Start accepted at T0; MAC occupies T1..TK; ACC at TK+1.
  - psum_out_valid first asserts at TK+2.
  - Output period is K+2 cycles with psum_out_ready held high.
- Stall rules:
  - psum_out_valid, once high, stays high with psum_out stable until psum_out_ready.
  - psum_in is consumed only in ACC.
- compute_done pulses the cycle after the final output handshake; busy drops in that same cycle.

## Configuration
- PE_PSUM_SAT_EN defined:
  - Every accumulate saturates to the signed PSUM_BITWIDTH range, i.e. [-2^(P-1), 2^(P-1)-1].
  - Once saturated, later products in the same output continue from the clamped value.
- PE_PSUM_SAT_EN undefined: two's-complement wrap, with no saturation logic.

## Test plan
- Basic pass: load W = {1,2,3} and A = {1,2,3,4,5}, then start with K=3, L=5, S=1, use_psum_in=0 -> outputs 14, 20, 26. First psum_out_valid 5 cycles after start; compute_done after the third handshake.
- Neighbour accumulate: same data with use_psum_in=1 and psum_in = 100 each time -> 114, 120, 126. Hold psum_in_valid low for 4 cycles on the second output -> psum_out delayed 4 cycles, values unchanged.
- Stride: same data with S=2 -> outputs 14, 26, then compute_done.
- Back-pressure: psum_out_ready low for 6 cycles -> psum_out_valid held and psum_out stable, no MAC progress.
- Config errors: start with K=0, with L=2 < K=3, or with S=0 -> one cfg_err pulse each, busy stays 0.
- Overflow: K=3 with all weights and acts 32767.
  - With PE_PSUM_SAT_EN -> output 2147483647.
  - Without it -> -1073938429.
  - Reset asserted mid-MAC -> IDLE next cycle, no compute_done.
